// File: rtl/l_next_pkg.sv
// Shared types for the I/D next-level arbiter: FSM states, requester ids, default widths.
package l_next_pkg;

  localparam int ADDR_W_DEF = 26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_D) ? REQ_I : REQ_D;
  endfunction

endpackage

// File: rtl/l_next_tmr.sv
// Saturating BUSY-cycle counter; expire is high during the TIMEOUT-th enabled cycle
// so the FSM leaves BUSY after exactly TIMEOUT cycles without an ack.
module l_next_tmr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q >= LIMIT_M1);

endmodule

// File: rtl/l_next_arbiter.sv
// Round-robin arbiter sharing one next-level port between I-cache and D-cache.
// Each transaction runs IDLE -> GRANT -> BUSY -> DONE; BUSY is bounded by a timeout.
module l_next_arbiter
  import l_next_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_add_in,
  output logic              i_gnt,
  output logic              i_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_add_in,
  input  logic              d_we,
  output logic              d_gnt,
  output logic              d_done,
  output logic              nx_req,
  output logic [ADDR_W-1:0] nx_add,
  output logic              nx_we,
  input  logic              nx_ack,
  output logic              err
);

  state_t            state_q, state_d;
  req_id_t           winner_q, winner_d;
  req_id_t           ptr_q, ptr_d;
  req_id_t           pick;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              tmr_expire;

  l_next_tmr #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_GRANT),
    .en     (state_q == ST_BUSY),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_req || d_req) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_BUSY;
      ST_BUSY:  if (nx_ack || tmr_expire) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ptr_q names the requester that wins a tie; it flips away from whoever is granted
  always_comb begin
    pick = (i_req && d_req) ? ptr_q : (d_req ? REQ_D : REQ_I);
  end

  always_comb begin
    winner_d = winner_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    we_d     = we_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          winner_d = pick;
          ptr_d    = other_req(pick);
          addr_d   = (pick == REQ_D) ? d_add_in : i_add_in;
          we_d     = (pick == REQ_D) ? d_we : 1'b0;
        end
      end
      ST_GRANT: err_d = 1'b0;
      ST_BUSY:  if (nx_ack || tmr_expire) err_d = !nx_ack;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      winner_q <= REQ_D;
      ptr_q    <= REQ_D;
      addr_q   <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      err_q    <= err_d;
    end
  end

  // Address and write flag are only driven while the request is live
  always_comb begin
    i_gnt  = 1'b0;
    d_gnt  = 1'b0;
    i_done = 1'b0;
    d_done = 1'b0;
    nx_req = 1'b0;
    nx_add = '0;
    nx_we  = 1'b0;
    err    = 1'b0;
    case (state_q)
      ST_GRANT: begin
        i_gnt = (winner_q == REQ_I);
        d_gnt = (winner_q == REQ_D);
      end
      ST_BUSY: begin
        nx_req = 1'b1;
        nx_add = addr_q;
        nx_we  = we_q;
      end
      ST_DONE: begin
        i_done = (winner_q == REQ_I);
        d_done = (winner_q == REQ_D);
        err    = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l_next_arbiter.sv
// Directed bench for l_next_arbiter: one task per scenario, inline checks, hand-computed values.
module tb_l_next_arbiter;

  localparam int ADDR_W  = 26;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, d_req, d_we, nx_ack;
  logic [ADDR_W-1:0] i_add_in, d_add_in;
  logic              i_gnt, i_done, d_gnt, d_done, nx_req, nx_we, err;
  logic [ADDR_W-1:0] nx_add;
  logic [ADDR_W+6:0] outs;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  assign outs = {i_gnt, d_gnt, i_done, d_done, nx_req, nx_we, err, nx_add};

  l_next_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_add_in(i_add_in), .i_gnt(i_gnt), .i_done(i_done),
    .d_req(d_req), .d_add_in(d_add_in), .d_we(d_we), .d_gnt(d_gnt), .d_done(d_done),
    .nx_req(nx_req), .nx_add(nx_add), .nx_we(nx_we), .nx_ack(nx_ack), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    total_cnt++; if (outs !== '0) $display("FAIL reset_outs: got %h want 0", outs); else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++; if (outs !== '0) $display("FAIL reset_idle: got %h want 0", outs); else pass_cnt++;
  endtask

  task automatic test_d_write();
    d_req = 1'b1; d_add_in = 26'h0000ABC; d_we = 1'b1;
    step();
    total_cnt++; if ({i_gnt, d_gnt, nx_req} !== 3'b010) $display("FAIL dwr_gnt: got %b want 010", {i_gnt, d_gnt, nx_req}); else pass_cnt++;
    step();
    total_cnt++; if ({nx_req, nx_we, nx_add} !== {2'b11, 26'h0000ABC}) $display("FAIL dwr_busy: got %b%b %h want 11 0000abc", nx_req, nx_we, nx_add); else pass_cnt++;
    step(); step(); step();
    total_cnt++; if ({nx_req, d_done} !== 2'b10) $display("FAIL dwr_wait: got %b want 10", {nx_req, d_done}); else pass_cnt++;
    nx_ack = 1'b1;
    step();
    nx_ack = 1'b0; d_req = 1'b0;
    total_cnt++; if ({d_done, i_done, err, nx_req} !== 4'b1000) $display("FAIL dwr_done: got %b want 1000", {d_done, i_done, err, nx_req}); else pass_cnt++;
    step();
    total_cnt++; if (outs !== '0) $display("FAIL dwr_after: got %h want 0", outs); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_d;
    logic       got;
    exp_d = 4'b0101;
    rst = 1'b1; step(); rst = 1'b0;
    i_req = 1'b1; i_add_in = 26'h0000111; d_req = 1'b1; d_add_in = 26'h0000222; d_we = 1'b0;
    for (int t = 0; t < 4; t++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        step();
        if (i_gnt || d_gnt) got = 1'b1;
      end
      total_cnt++; if ({i_gnt, d_gnt} !== (exp_d[t] ? 2'b01 : 2'b10)) $display("FAIL rr_gnt%0d: got %b want %b", t, {i_gnt, d_gnt}, exp_d[t] ? 2'b01 : 2'b10); else pass_cnt++;
      step();
      total_cnt++; if (nx_add !== (exp_d[t] ? 26'h0000222 : 26'h0000111)) $display("FAIL rr_addr%0d: got %h", t, nx_add); else pass_cnt++;
      nx_ack = 1'b1;
      step();
      nx_ack = 1'b0;
      total_cnt++; if ({i_done, d_done} !== (exp_d[t] ? 2'b01 : 2'b10)) $display("FAIL rr_done%0d: got %b want %b", t, {i_done, d_done}, exp_d[t] ? 2'b01 : 2'b10); else pass_cnt++;
    end
    i_req = 1'b0; d_req = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int busy;
    i_req = 1'b1; i_add_in = 26'h3FFFFFF;
    step();
    total_cnt++; if ({i_gnt, d_gnt} !== 2'b10) $display("FAIL to_gnt: got %b want 10", {i_gnt, d_gnt}); else pass_cnt++;
    step();
    total_cnt++; if ({nx_req, nx_we, nx_add} !== {2'b10, 26'h3FFFFFF}) $display("FAIL to_busy: got %b%b %h", nx_req, nx_we, nx_add); else pass_cnt++;
    busy = 1;
    for (int c = 0; c < 300 && nx_req; c++) begin
      step();
      if (nx_req) busy++;
    end
    total_cnt++; if (busy !== TIMEOUT) $display("FAIL to_cycles: got %0d want %0d", busy, TIMEOUT); else pass_cnt++;
    total_cnt++; if ({i_done, d_done, err} !== 3'b101) $display("FAIL to_done: got %b want 101", {i_done, d_done, err}); else pass_cnt++;
    i_req = 1'b0;
    step();
    total_cnt++; if (outs !== '0) $display("FAIL to_idle: got %h want 0", outs); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_add_in = 26'h1555555; d_we = 1'b1;
    step(); step(); step();
    total_cnt++; if (nx_req !== 1'b1) $display("FAIL rm_busy: got %b want 1", nx_req); else pass_cnt++;
    rst = 1'b1; d_req = 1'b0;
    step();
    rst = 1'b0;
    total_cnt++; if (outs !== '0) $display("FAIL rm_rst: got %h want 0", outs); else pass_cnt++;
    step();
    nx_ack = 1'b1;
    step();
    nx_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total_cnt++; if (outs !== '0) $display("FAIL rm_quiet%0d: got %h want 0", c, outs); else pass_cnt++;
      step();
    end
  endtask

  task automatic test_addr_hold();
    i_req = 1'b1; i_add_in = 26'h1234567;
    step(); step();
    total_cnt++; if (nx_add !== 26'h1234567) $display("FAIL ah_addr: got %h want 1234567", nx_add); else pass_cnt++;
    i_add_in = 26'h2AAAAAA; i_req = 1'b0;
    step();
    total_cnt++; if ({nx_req, nx_we, nx_add} !== {2'b10, 26'h1234567}) $display("FAIL ah_hold: got %b%b %h", nx_req, nx_we, nx_add); else pass_cnt++;
    nx_ack = 1'b1;
    step();
    nx_ack = 1'b0;
    total_cnt++; if ({i_done, d_done, err} !== 3'b100) $display("FAIL ah_done: got %b want 100", {i_done, d_done, err}); else pass_cnt++;
    step();
    total_cnt++; if (outs !== '0) $display("FAIL ah_idle: got %h want 0", outs); else pass_cnt++;
  endtask

  task automatic test_idle_ack();
    nx_ack = 1'b1;
    step();
    nx_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total_cnt++; if (outs !== '0) $display("FAIL ia_quiet%0d: got %h want 0", c, outs); else pass_cnt++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; nx_ack = 1'b0;
    i_add_in = '0; d_add_in = '0;
    test_reset();
    test_d_write();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_addr_hold();
    test_idle_ack();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
